// File: rtl/tea_iter_core.sv
// Iterative TEA encrypt/decrypt engine: ROUNDS_PER_CYCLE rounds per enabled clock,
// one 64-bit block in flight, valid/ready on both sides.

module tea_round #(
    parameter logic [31:0] DELTA = 32'h9e37_79b9
) (
    input  logic         encrypt,
    input  logic [127:0] key,
    input  logic [31:0]  v0,
    input  logic [31:0]  v1,
    input  logic [31:0]  sum,
    output logic [31:0]  v0_next,
    output logic [31:0]  v1_next,
    output logic [31:0]  sum_next
);
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] sum_enc, v0_enc, v1_enc;
    logic [31:0] sum_dec, v0_dec, v1_dec;

    function automatic logic [31:0] mix(input logic [31:0] x, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
        return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
    endfunction

    assign {k0, k1, k2, k3} = key;

    // Encrypt bumps sum first; decrypt undoes the half-rounds in reverse, then drops sum.
    assign sum_enc = sum + DELTA;
    assign v0_enc  = v0 + mix(v1, sum_enc, k0, k1);
    assign v1_enc  = v1 + mix(v0_enc, sum_enc, k2, k3);

    assign v1_dec  = v1 - mix(v0, sum, k2, k3);
    assign v0_dec  = v0 - mix(v1_dec, sum, k0, k1);
    assign sum_dec = sum - DELTA;

    assign v0_next  = encrypt ? v0_enc  : v0_dec;
    assign v1_next  = encrypt ? v1_enc  : v1_dec;
    assign sum_next = encrypt ? sum_enc : sum_dec;
endmodule

module tea_iter_core #(
    parameter int          ROUNDS           = 32,
    parameter int          ROUNDS_PER_CYCLE = 1,
    parameter logic [31:0] DELTA            = 32'h9e37_79b9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         encrypt,
    input  logic [63:0]  inBlock64,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  outBlock64,
    output logic         busy
);
    localparam int CW = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] STEP = CW'(ROUNDS_PER_CYCLE);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS);
    localparam logic [63:0] SUM_PROD = 64'(DELTA) * 64'(ROUNDS);
    localparam logic [31:0] SUM_DEC  = SUM_PROD[31:0];

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [31:0]    v0, v1, sum;
    logic [127:0]   key_q;
    logic           mode;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;

    logic [ROUNDS_PER_CYCLE:0][31:0] v0_c, v1_c, sum_c;

    assign v0_c[0]  = v0;
    assign v1_c[0]  = v1;
    assign sum_c[0] = sum;

    generate
        for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
            tea_round #(.DELTA(DELTA)) u_round (
                .encrypt  (mode),
                .key      (key_q),
                .v0       (v0_c[i]),
                .v1       (v1_c[i]),
                .sum      (sum_c[i]),
                .v0_next  (v0_c[i+1]),
                .v1_next  (v1_c[i+1]),
                .sum_next (sum_c[i+1])
            );
        end
    endgenerate

    assign cnt_next = cnt + STEP;
    // rst gates in_ready directly so it drops the moment reset asserts.
    assign in_ready = rst && ena && (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            v0         <= '0;
            v1         <= '0;
            sum        <= '0;
            key_q      <= '0;
            mode       <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            outBlock64 <= '0;
            busy       <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        v0    <= inBlock64[63:32];
                        v1    <= inBlock64[31:0];
                        key_q <= key;
                        mode  <= encrypt;
                        sum   <= encrypt ? 32'h0 : SUM_DEC;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    v0  <= v0_c[ROUNDS_PER_CYCLE];
                    v1  <= v1_c[ROUNDS_PER_CYCLE];
                    sum <= sum_c[ROUNDS_PER_CYCLE];
                    cnt <= cnt_next;
                    if (cnt_next == LAST) begin
                        outBlock64 <= {v0_c[ROUNDS_PER_CYCLE], v1_c[ROUNDS_PER_CYCLE]};
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
